// File: rtl/constraint_sample_gen.sv
// ---------------------------------------------------------------------------
// constraint_sample_gen
//
// Generates pseudo-random candidate assignment vectors with a 64-bit xorshift
// PRNG and presents them to an external combinational constraint checker.
// Candidates the checker accepts are delivered on a valid/ready stream;
// rejected candidates are discarded. A run ends with a done_o pulse once
// num_i samples have been delivered, or with a fail_o pulse when MAX_TRIES
// consecutive candidates are rejected for a single sample.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         begin a run (accepted only while idle)
//   seed_i          PRNG seed, latched on an accepted start (0 maps to 1)
//   num_i           number of samples requested, latched on accepted start
//   cand_o          current candidate, wired to the checker inputs
//   sat_i           checker verdict for cand_o (combinational from cand_o)
//   sample_o        accepted solution
//   sample_valid_o  sample_o valid
//   sample_ready_i  sink ready
//   busy_o          run in progress
//   done_o          one-cycle pulse: all requested samples delivered
//   fail_o          one-cycle pulse: try budget exhausted
//   tries_o         rejections since the last accepted sample
// ---------------------------------------------------------------------------
module constraint_sample_gen #(
    parameter int WIDTH     = 64,
    parameter int CNT_W     = 16,
    parameter int MAX_TRIES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [63:0]      seed_i,
    input  logic [CNT_W-1:0] num_i,
    output logic [WIDTH-1:0] cand_o,
    input  logic             sat_i,
    output logic [WIDTH-1:0] sample_o,
    output logic             sample_valid_o,
    input  logic             sample_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] tries_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_HOLD,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [63:0]      r_prng;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_tries;
    logic [WIDTH-1:0] r_sample;

    logic [63:0]      w_s1;
    logic [63:0]      w_s2;
    logic [63:0]      w_prng_step;
    logic [63:0]      w_seed;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_last_try;

    // xorshift64 step; a zero state would lock up, so a zero seed becomes 1.
    assign w_s1        = r_prng ^ (r_prng << 13);
    assign w_s2        = w_s1 ^ (w_s1 >> 7);
    assign w_prng_step = w_s2 ^ (w_s2 << 17);
    assign w_seed      = (seed_i == 64'd0) ? 64'd1 : seed_i;

    assign w_count_inc = r_count + 1'b1;
    assign w_last_try  = (r_tries == CNT_W'(MAX_TRIES - 1));

    assign cand_o   = r_prng[WIDTH-1:0];
    assign sample_o = r_sample;
    assign tries_o  = r_tries;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: the default assignment up front keeps this block free of latches
    // for any branch that does not assign w_next_state.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_next_state = (num_i == '0) ? ST_DONE : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (sat_i) begin
                    w_next_state = ST_HOLD;
                end else if (w_last_try) begin
                    w_next_state = ST_FAIL;
                end
            end
            ST_HOLD: begin
                if (sample_ready_i) begin
                    w_next_state = (w_count_inc == r_num) ? ST_DONE : ST_CHECK;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            ST_FAIL: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs decoded from state
    // ---------------------------------------------------------------------
    always_comb begin
        busy_o         = 1'b0;
        sample_valid_o = 1'b0;
        done_o         = 1'b0;
        fail_o         = 1'b0;
        unique case (r_state)
            ST_IDLE:  ;
            ST_CHECK: busy_o = 1'b1;
            ST_HOLD: begin
                busy_o         = 1'b1;
                sample_valid_o = 1'b1;
            end
            ST_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            ST_FAIL: begin
                busy_o = 1'b1;
                fail_o = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: PRNG, counters, captured sample
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prng   <= '0;
            r_num    <= '0;
            r_count  <= '0;
            r_tries  <= '0;
            r_sample <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_prng  <= w_seed;
                        r_num   <= num_i;
                        r_count <= '0;
                        r_tries <= '0;
                    end
                end
                ST_CHECK: begin
                    // An accepted candidate freezes the PRNG so cand_o and
                    // sample_o agree until the sink takes the sample. On the
                    // final rejection tries_o is left at MAX_TRIES-1.
                    if (sat_i) begin
                        r_sample <= cand_o;
                    end else if (!w_last_try) begin
                        r_prng  <= w_prng_step;
                        r_tries <= r_tries + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (sample_ready_i) begin
                        r_count <= w_count_inc;
                        r_tries <= '0;
                        r_prng  <= w_prng_step;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_constraint_sample_gen.sv
module tb_constraint_sample_gen;

    localparam int WIDTH     = 64;
    localparam int CNT_W     = 16;
    localparam int MAX_TRIES = 4;

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic [63:0]      seed_i;
    logic [CNT_W-1:0] num_i;
    logic [WIDTH-1:0] cand_o;
    logic             sat_i;
    logic [WIDTH-1:0] sample_o;
    logic             sample_valid_o;
    logic             sample_ready_i;
    logic             busy_o;
    logic             done_o;
    logic             fail_o;
    logic [CNT_W-1:0] tries_o;

    int n_pass;
    int n_total;
    int sat_mode;   // 0: checker accepts all, 1: rejects all, 2: parity checker

    constraint_sample_gen #(
        .WIDTH    (WIDTH),
        .CNT_W    (CNT_W),
        .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .seed_i        (seed_i),
        .num_i         (num_i),
        .cand_o        (cand_o),
        .sat_i         (sat_i),
        .sample_o      (sample_o),
        .sample_valid_o(sample_valid_o),
        .sample_ready_i(sample_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .fail_o        (fail_o),
        .tries_o       (tries_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference xorshift64 step, straight from the arithmetic definition.
    function automatic logic [63:0] xs(input logic [63:0] s);
        logic [63:0] a;
        a = s ^ (s << 13);
        a = a ^ (a >> 7);
        return a ^ (a << 17);
    endfunction

    // External checker: accepts candidates with odd parity over a mask.
    function automatic logic chk(input logic [63:0] c);
        return ^(c & 64'h0123_4567_89AB_CDEF);
    endfunction

    assign sat_i = (sat_mode == 0) ? 1'b1 : (sat_mode == 1) ? 1'b0 : chk(cand_o);

    task automatic start_run(input logic [63:0] seed, input logic [CNT_W-1:0] num);
        @(negedge clk);
        start_i = 1'b1;
        seed_i  = seed;
        num_i   = num;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_total++; if (cand_o !== '0)         $display("FAIL reset_cand got=%h exp=0", cand_o);        else n_pass++;
        n_total++; if (sample_o !== '0)       $display("FAIL reset_sample got=%h exp=0", sample_o);    else n_pass++;
        n_total++; if (tries_o !== '0)        $display("FAIL reset_tries got=%0d exp=0", tries_o);     else n_pass++;
        n_total++; if ({sample_valid_o, busy_o, done_o, fail_o} !== 4'b0)
            $display("FAIL reset_flags got=%b exp=0000", {sample_valid_o, busy_o, done_o, fail_o}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (busy_o !== 1'b0)       $display("FAIL reset_idle_busy got=%b exp=0", busy_o);   else n_pass++;
    endtask

    task automatic test_basic();
        sat_mode = 0;
        sample_ready_i = 1'b1;
        start_run(64'h1, 16'd1);
        n_total++; if (cand_o !== 64'h1)      $display("FAIL basic_cand got=%h exp=1", cand_o);        else n_pass++;
        n_total++; if (busy_o !== 1'b1)       $display("FAIL basic_busy got=%b exp=1", busy_o);        else n_pass++;
        n_total++; if (sample_valid_o !== 1'b0) $display("FAIL basic_early_valid got=%b exp=0", sample_valid_o); else n_pass++;
        @(negedge clk);
        n_total++; if (sample_valid_o !== 1'b1) $display("FAIL basic_valid got=%b exp=1", sample_valid_o); else n_pass++;
        n_total++; if (sample_o !== 64'h1)    $display("FAIL basic_sample got=%h exp=1", sample_o);    else n_pass++;
        @(negedge clk);
        n_total++; if (done_o !== 1'b1)       $display("FAIL basic_done got=%b exp=1", done_o);        else n_pass++;
        n_total++; if (sample_valid_o !== 1'b0) $display("FAIL basic_valid_drop got=%b exp=0", sample_valid_o); else n_pass++;
        @(negedge clk);
        n_total++; if (done_o !== 1'b0)       $display("FAIL basic_done_pulse got=%b exp=0", done_o);  else n_pass++;
        n_total++; if (busy_o !== 1'b0)       $display("FAIL basic_busy_drop got=%b exp=0", busy_o);   else n_pass++;
    endtask

    task automatic test_two_samples();
        sat_mode = 0;
        sample_ready_i = 1'b1;
        start_run(64'h1, 16'd2);
        @(negedge clk);
        n_total++; if (sample_valid_o !== 1'b1 || sample_o !== 64'h1)
            $display("FAIL two_first got=%b/%h exp=1/%h", sample_valid_o, sample_o, 64'h1); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_total++; if (sample_valid_o !== 1'b1 || sample_o !== 64'h40822041)
            $display("FAIL two_second got=%b/%h exp=1/%h", sample_valid_o, sample_o, 64'h40822041); else n_pass++;
        @(negedge clk);
        n_total++; if (done_o !== 1'b1)       $display("FAIL two_done got=%b exp=1", done_o);          else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_seed_zero();
        sat_mode = 0;
        sample_ready_i = 1'b1;
        start_run(64'h0, 16'd1);
        n_total++; if (cand_o !== 64'h1)      $display("FAIL seed0_cand got=%h exp=1", cand_o);        else n_pass++;
        @(negedge clk);
        n_total++; if (sample_o !== 64'h1)    $display("FAIL seed0_sample got=%h exp=1", sample_o);    else n_pass++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_fail();
        logic [63:0] s;
        sat_mode = 1;
        sample_ready_i = 1'b1;
        s = {$urandom, $urandom} | 64'h1;
        start_run(s, 16'd3);
        for (int i = 0; i < MAX_TRIES; i++) begin
            n_total++; if (tries_o !== CNT_W'(i)) $display("FAIL fail_tries got=%0d exp=%0d", tries_o, i); else n_pass++;
            n_total++; if (cand_o !== s)      $display("FAIL fail_cand got=%h exp=%h", cand_o, s);     else n_pass++;
            n_total++; if (sample_valid_o !== 1'b0 || fail_o !== 1'b0)
                $display("FAIL fail_early got=%b%b exp=00", sample_valid_o, fail_o); else n_pass++;
            s = xs(s);
            @(negedge clk);
        end
        n_total++; if (fail_o !== 1'b1)       $display("FAIL fail_pulse got=%b exp=1", fail_o);        else n_pass++;
        @(negedge clk);
        n_total++; if (fail_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL fail_idle got=%b%b exp=00", fail_o, busy_o); else n_pass++;
        n_total++; if (tries_o !== CNT_W'(MAX_TRIES - 1))
            $display("FAIL fail_tries_hold got=%0d exp=%0d", tries_o, MAX_TRIES - 1); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [63:0] s0;
        int          n_xfer;
        sat_mode = 0;
        sample_ready_i = 1'b0;
        s0 = {$urandom, $urandom} | 64'h2;
        start_run(s0, 16'd2);
        @(negedge clk);
        n_xfer = 0;
        for (int i = 0; i < 10; i++) begin
            // A start while busy must not disturb the run.
            start_i = (i == 3);
            seed_i  = 64'hDEAD_BEEF;
            num_i   = 16'd7;
            n_total++; if (sample_valid_o !== 1'b1 || sample_o !== s0 || cand_o !== s0)
                $display("FAIL bp_hold got=%b/%h/%h exp=1/%h/%h", sample_valid_o, sample_o, cand_o, s0, s0); else n_pass++;
            @(negedge clk);
        end
        start_i = 1'b0;
        sample_ready_i = 1'b1;
        if (sample_valid_o) n_xfer++;
        @(negedge clk);
        sample_ready_i = 1'b0;
        if (sample_valid_o) n_xfer++;
        n_total++; if (n_xfer !== 1)          $display("FAIL bp_one_xfer got=%0d exp=1", n_xfer);      else n_pass++;
        n_total++; if (cand_o !== xs(s0))     $display("FAIL bp_advance got=%h exp=%h", cand_o, xs(s0)); else n_pass++;
        @(negedge clk);
        n_total++; if (sample_valid_o !== 1'b1 || sample_o !== xs(s0) || done_o !== 1'b0)
            $display("FAIL bp_second got=%b/%h/%b exp=1/%h/0", sample_valid_o, sample_o, done_o, xs(s0)); else n_pass++;
        sample_ready_i = 1'b1;
        @(negedge clk);
        n_total++; if (done_o !== 1'b1)       $display("FAIL bp_done got=%b exp=1", done_o);           else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_num_zero();
        sat_mode = 0;
        sample_ready_i = 1'b1;
        start_run({$urandom, $urandom}, 16'd0);
        n_total++; if (done_o !== 1'b1 || sample_valid_o !== 1'b0)
            $display("FAIL num0 got=%b%b exp=10", done_o, sample_valid_o); else n_pass++;
        @(negedge clk);
        n_total++; if (busy_o !== 1'b0)       $display("FAIL num0_idle got=%b exp=0", busy_o);         else n_pass++;
    endtask

    task automatic test_reset_mid();
        int pulses;
        sat_mode = 1;
        start_run({$urandom, $urandom}, 16'd2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if ({cand_o, sample_o, tries_o} !== '0 || {sample_valid_o, busy_o, done_o, fail_o} !== 4'b0)
            $display("FAIL midrst got=%h/%h/%0d/%b exp=0", cand_o, sample_o, tries_o,
                     {sample_valid_o, busy_o, done_o, fail_o}); else n_pass++;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_o || fail_o) pulses++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_o || fail_o || busy_o) pulses++;
        end
        n_total++; if (pulses !== 0)          $display("FAIL midrst_pulses got=%0d exp=0", pulses);    else n_pass++;
    endtask

    // Random run checked against a queue of expected samples built from the
    // accept/reject rules.
    task automatic run_random(input logic [63:0] seed, input int num, input int pct);
        logic [63:0] exp_q[$];
        logic [63:0] s;
        bit          exp_fail;
        bit          done_seen;
        bit          fail_seen;
        int          t;
        int          got;
        int          cyc;

        sat_mode = 2;
        exp_fail = 0;
        s = (seed == 64'd0) ? 64'd1 : seed;
        for (int k = 0; k < num && !exp_fail; k++) begin
            t = 0;
            forever begin
                if (chk(s)) begin
                    exp_q.push_back(s);
                    s = xs(s);
                    break;
                end
                if (t == MAX_TRIES - 1) begin
                    exp_fail = 1;
                    break;
                end
                s = xs(s);
                t++;
            end
        end

        sample_ready_i = 1'b0;
        start_run(seed, CNT_W'(num));
        got = 0;
        done_seen = 0;
        fail_seen = 0;
        cyc = 0;
        while (!done_seen && !fail_seen && cyc < 2000) begin
            if (done_o) done_seen = 1;
            if (fail_o) fail_seen = 1;
            sample_ready_i = ($urandom_range(99) < pct);
            if (sample_valid_o && sample_ready_i) begin
                n_total++;
                if (got >= exp_q.size())
                    $display("FAIL rnd_extra got=%h exp=none", sample_o);
                else if (sample_o !== exp_q[got])
                    $display("FAIL rnd_sample idx=%0d got=%h exp=%h", got, sample_o, exp_q[got]);
                else
                    n_pass++;
                got++;
            end
            if (!done_seen && !fail_seen) @(negedge clk);
            cyc++;
        end
        n_total++; if (cyc >= 2000)           $display("FAIL rnd_timeout got=%0d exp<2000", cyc);      else n_pass++;
        n_total++; if (got !== exp_q.size())  $display("FAIL rnd_count got=%0d exp=%0d", got, exp_q.size()); else n_pass++;
        n_total++; if (fail_seen !== exp_fail || done_seen !== !exp_fail)
            $display("FAIL rnd_end got=done%0d/fail%0d exp=fail%0d", done_seen, fail_seen, exp_fail); else n_pass++;
        @(negedge clk);
        n_total++; if (busy_o !== 1'b0 || done_o !== 1'b0 || fail_o !== 1'b0)
            $display("FAIL rnd_idle got=%b%b%b exp=000", busy_o, done_o, fail_o); else n_pass++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 16; r++) begin
            run_random({$urandom, $urandom}, $urandom_range(0, 6), $urandom_range(30, 100));
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        sat_mode = 0;
        rst_n = 1'b0;
        start_i = 1'b0;
        seed_i = '0;
        num_i = '0;
        sample_ready_i = 1'b0;

        test_reset();
        test_basic();
        test_two_samples();
        test_seed_zero();
        test_fail();
        test_backpressure();
        test_num_zero();
        test_reset_mid();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
